alu_share_arbiter: RTL

Shares the single combinational ALU between two requesters, e.g. the integer pipe (port 0) and a coprocessor/debug port (port 1). Uses a valid/ready handshake on each request port and arbitrates round-robin. Registers operands into the ALU and holds them for a per-op occupancy; MUL occupies the ALU for a multi-cycle path. Returns one registered response tagged with the winning port id.

---
 rtl/alu_share_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready
// requesters. Each granted request registers its op and operands into the ALU
// and holds them for a per-op occupancy. The arbiter then returns one
// registered response, tagged with the id of the winning port.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN gives port 0 strict priority
// instead of round-robin.
module alu_share_arbiter #(
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned OTHER_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic [31:0] alu_in0_o,
    output logic [31:0] alu_in1_o,
    output logic [2:0]  alu_op_o,
    input  logic [31:0] alu_out_i,
    input  logic        alu_zero_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_zero_o,
    output logic        resp_id_o,
    output logic        busy_o
);

    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_NOP    = 3'b011;
    // The counter is loaded with occupancy-1, so EXEC lasts exactly LAT cycles
    localparam logic [3:0] MUL_CNT   = 4'(MUL_LAT - 1);
    localparam logic [3:0] OTHER_CNT = 4'(OTHER_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant0, grant1, grant_any;
    logic [2:0]  sel_op;
    logic [31:0] sel_a, sel_b;
    logic [31:0] in0_q, in1_q;
    logic [2:0]  op_q;
    logic [31:0] rdata_q;
    logic        rzero_q;
    logic        id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Strict priority: port 1 only wins when port 0 is idle
    always_comb begin
        grant0 = (state_q == ST_IDLE) && req0_valid_i;
        grant1 = (state_q == ST_IDLE) && req1_valid_i && !req0_valid_i;
    end
`else
    logic last_grant_q, last_grant_d;

    // Round-robin: on contention the port that did not win last time is served
    always_comb begin
        grant0 = (state_q == ST_IDLE) && req0_valid_i && (!req1_valid_i || last_grant_q);
        grant1 = (state_q == ST_IDLE) && req1_valid_i && (!req0_valid_i || !last_grant_q);
        last_grant_d = (grant0 || grant1) ? grant1 : last_grant_q;
    end

    // Last-grant register; resets to port 1 so port 0 wins the first tie
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
`endif

    // Mux the winning port's request onto the capture path
    always_comb begin
        grant_any = grant0 || grant1;
        sel_op    = grant1 ? req1_op_i : req0_op_i;
        sel_a     = grant1 ? req1_a_i  : req0_a_i;
        sel_b     = grant1 ? req1_b_i  : req0_b_i;
    end

    // FSM state register and occupancy counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: grant, hold the ALU for its occupancy, then wait for the consumer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = ST_EXEC;
                    cnt_d   = (sel_op == OP_MUL) ? MUL_CNT : OTHER_CNT;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; readies are gated by reset so nothing is accepted while held
    always_comb begin
        req0_ready_o = rst_i && grant0;
        req1_ready_o = rst_i && grant1;
        busy_o       = (state_q != ST_IDLE);
        resp_valid_o = (state_q == ST_RESP);
    end

    // Operand/op capture on grant and result capture on the last EXEC cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in0_q   <= 32'd0;
            in1_q   <= 32'd0;
            op_q    <= OP_NOP;
            id_q    <= 1'b0;
            rdata_q <= 32'd0;
            rzero_q <= 1'b0;
        end else begin
            if (grant_any) begin
                in0_q <= sel_a;
                in1_q <= sel_b;
                op_q  <= sel_op;
                id_q  <= grant1;
            end
            if ((state_q == ST_EXEC) && (cnt_q == 4'd0)) begin
                rdata_q <= alu_out_i;
                rzero_q <= alu_zero_i;
            end
        end
    end

    assign alu_in0_o   = in0_q;
    assign alu_in1_o   = in1_q;
    assign alu_op_o    = op_q;
    assign resp_data_o = rdata_q;
    assign resp_zero_o = rzero_q;
    assign resp_id_o   = id_q;

endmodule
